bsg_wormhole_link_arbiter_in: RTL and testbench

- Shares one serialized wormhole link among els_p flit-stream requesters, e.g. several packet-to-flit serializers feeding one router input port.
- Selects a requester round-robin at header-flit boundaries and locks the grant for the whole packet, using the header len field.
- Forwards flits with zero latency, so downstream sees an unbroken packet per grant.

---
 rtl/bsg_wormhole_link_arbiter_in_pkg.sv | 15 +
 rtl/bsg_wormhole_rr_picker.sv | 31 +++
 rtl/bsg_wormhole_link_arbiter_in.sv | 127 ++++++++++++
 tb/tb_bsg_wormhole_link_arbiter_in.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_wormhole_link_arbiter_in_pkg.sv
// Shared types and helpers for the wormhole link-input arbiter and its
// round-robin picker.
package bsg_wormhole_link_arbiter_in_pkg;

    typedef enum logic {
        e_idle = 1'b0,
        e_busy = 1'b1
    } arb_state_e;

    // Index width that stays at least one bit wide for degenerate counts.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_wormhole_rr_picker.sv
// Combinational round-robin first-one search starting at ptr_i.
// When nothing is valid, grant_o falls back to ptr_i.
module bsg_wormhole_rr_picker
    import bsg_wormhole_link_arbiter_in_pkg::*;
#(
    parameter int els_p      = 4,
    parameter int id_width_p = safe_clog2(els_p)
) (
    input  logic [els_p-1:0]      v_i,
    input  logic [id_width_p-1:0] ptr_i,
    output logic [id_width_p-1:0] grant_o,
    output logic                  found_o
);

    logic [id_width_p-1:0] cand;

    // Walk from the farthest candidate back to ptr_i so the closest valid wins.
    always_comb begin
        grant_o = ptr_i;
        found_o = 1'b0;
        cand    = '0;
        for (int k = els_p - 1; k >= 0; k--) begin
            cand = id_width_p'((int'(ptr_i) + k) % els_p);
            if (v_i[cand]) begin
                grant_o = cand;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bsg_wormhole_link_arbiter_in.sv
// Packet-granular round-robin arbiter sharing one wormhole link among els_p
// flit streams; the grant is locked for the header's len body flits.
//
//   state  | meaning
//   e_idle | header boundary, round-robin selection from rr_ptr_q
//   e_busy | body of a locked packet, lock_q owns the link, cnt_q flits left
module bsg_wormhole_link_arbiter_in
    import bsg_wormhole_link_arbiter_in_pkg::*;
#(
    parameter int els_p        = 4,
    parameter int flit_width_p = 32,
    parameter int cord_width_p = 5,
    parameter int len_width_p  = 4,
    localparam int id_width_lp = safe_clog2(els_p)
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic [els_p*flit_width_p-1:0] link_data_i,
    input  logic [els_p-1:0]              link_v_i,
    output logic [els_p-1:0]              link_ready_and_o,
    output logic [flit_width_p-1:0]       link_data_o,
    output logic                          link_v_o,
    input  logic                          link_ready_and_i,
    output logic [id_width_lp-1:0]        grant_id_o,
    output logic                          busy_o
);

    arb_state_e             state_q, state_d;
    logic [len_width_p-1:0] cnt_q, cnt_d;
    logic [id_width_lp-1:0] lock_q, lock_d;
    logic [id_width_lp-1:0] rr_ptr_q, rr_ptr_d;

    logic [id_width_lp-1:0]  pick_id, sel_id;
    logic                    pick_found, sel_v, xfer;
    logic [flit_width_p-1:0] sel_flit;
    logic [len_width_p-1:0]  hdr_len;

    bsg_wormhole_rr_picker #(
        .els_p      (els_p),
        .id_width_p (id_width_lp)
    ) picker (
        .v_i     (link_v_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_id),
        .found_o (pick_found)
    );

    assign sel_id = (state_q == e_busy) ? lock_q : pick_id;

    always_comb begin
        sel_flit = '0;
        sel_v    = 1'b0;
        for (int i = 0; i < els_p; i++) begin
            if (sel_id == id_width_lp'(i)) begin
                sel_flit = link_data_i[i*flit_width_p +: flit_width_p];
                sel_v    = link_v_i[i];
            end
        end
    end

    // Handshake outputs are gated by reset so they drop the moment reset asserts.
    always_comb begin
        link_ready_and_o = '0;
        for (int i = 0; i < els_p; i++) begin
            link_ready_and_o[i] = reset_n_i & link_ready_and_i & (sel_id == id_width_lp'(i));
        end
    end

    assign link_v_o    = reset_n_i & ((state_q == e_busy) ? sel_v : pick_found);
    assign link_data_o = sel_flit;
    assign grant_id_o  = reset_n_i ? sel_id : '0;
    assign busy_o      = reset_n_i & (state_q == e_busy);

    assign xfer    = link_v_o & link_ready_and_i;
    assign hdr_len = sel_flit[cord_width_p +: len_width_p];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lock_d   = lock_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            e_idle: begin
                if (xfer) begin
                    rr_ptr_d = (sel_id == id_width_lp'(els_p - 1)) ? '0 : sel_id + 1'b1;
                    if (hdr_len != '0) begin
                        cnt_d   = hdr_len;
                        lock_d  = sel_id;
                        state_d = e_busy;
                    end
                end
            end
            e_busy: begin
                if (xfer) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == len_width_p'(1)) begin
                        state_d = e_idle;
                    end
                end
            end
            default: state_d = e_idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= e_idle;
            cnt_q    <= '0;
            lock_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lock_q   <= lock_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifndef SYNTHESIS
    // A stalled body flit must stay valid until the link takes it.
    locked_valid_held_a : assert property (
        @(posedge clk_i) disable iff (!reset_n_i)
        (state_q == e_busy && link_v_o && !link_ready_and_i) |=> link_v_i[lock_q]
    );
`endif

endmodule

// File: tb/tb_bsg_wormhole_link_arbiter_in.sv
// Randomized and directed checks of the link-input arbiter against a
// packet-ownership reference model.
module tb_bsg_wormhole_link_arbiter_in;

    localparam int ELS = 4;
    localparam int FW  = 32;
    localparam int CW  = 5;
    localparam int LW  = 4;
    localparam int IW  = 2;

    logic              clk_i = 1'b0;
    logic              reset_n_i = 1'b0;
    logic [ELS*FW-1:0] link_data_i = '0;
    logic [ELS-1:0]    link_v_i = '0;
    logic [ELS-1:0]    link_ready_and_o;
    logic [FW-1:0]     link_data_o;
    logic              link_v_o;
    logic              link_ready_and_i = 1'b0;
    logic [IW-1:0]     grant_id_o;
    logic              busy_o;

    bsg_wormhole_link_arbiter_in #(
        .els_p        (ELS),
        .flit_width_p (FW),
        .cord_width_p (CW),
        .len_width_p  (LW)
    ) dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .link_data_i      (link_data_i),
        .link_v_i         (link_v_i),
        .link_ready_and_o (link_ready_and_o),
        .link_data_o      (link_data_o),
        .link_v_o         (link_v_o),
        .link_ready_and_i (link_ready_and_i),
        .grant_id_o       (grant_id_o),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    // upstream sources and reference model
    logic [31:0] srcq[ELS][$];
    bit          held[ELS];
    bit          mute[ELS];
    int          seqn[ELS];
    int          m_owner, m_left, m_ptr;
    bit          exp_xfer;
    int          exp_sel, exp_len;
    int          p_valid, p_rdy, rdy_force;
    bit          chk_en = 1'b0;
    int          cyc = 0;
    int          c_sel, c_idx;
    bit          c_v;
    logic [ELS-1:0] c_rdy;

    logic [31:0] out_log[$];
    int          grant_log[$];
    bit          busy_log[$];
    int          cyc_log[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [31:0] mk_flit(input int src, input int sq, input int idx, input int len);
        if (idx == 0) return {8'(src), 8'(sq), 4'(idx), 3'b000, 4'(len), 5'd7};
        return {8'(src), 8'(sq), 4'(idx), 12'($urandom)};
    endfunction

    task automatic add_pkt(input int src, input int len);
        for (int f = 0; f <= len; f++) srcq[src].push_back(mk_flit(src, seqn[src], f, len));
        seqn[src]++;
    endtask

    task automatic clear_model();
        m_owner = -1; m_left = 0; m_ptr = 0;
        for (int i = 0; i < ELS; i++) begin
            srcq[i].delete();
            held[i] = 1'b0; mute[i] = 1'b0; seqn[i] = 0;
        end
    endtask

    task automatic clear_logs();
        out_log.delete(); grant_log.delete(); busy_log.delete(); cyc_log.delete();
    endtask

    function automatic bit vbit(input int i);
        return bit'(link_v_i >> i);
    endfunction

    // Per-cycle comparison against the model; also logs accepted flits.
    always @(negedge clk_i) begin
        cyc++;
        if (chk_en) begin
            if (!reset_n_i) begin
                chk("rst_link_v_o", 64'(link_v_o), 64'(0));
                chk("rst_ready_and_o", 64'(link_ready_and_o), 64'(0));
                chk("rst_busy_o", 64'(busy_o), 64'(0));
                chk("rst_grant_id_o", 64'(grant_id_o), 64'(0));
                exp_xfer = 1'b0;
            end else begin
                if (m_owner >= 0) begin
                    c_sel = m_owner;
                end else begin
                    c_sel = m_ptr;
                    for (int k = ELS - 1; k >= 0; k--) begin
                        c_idx = (m_ptr + k) % ELS;
                        if (vbit(c_idx)) c_sel = c_idx;
                    end
                end
                c_v   = vbit(c_sel);
                c_rdy = link_ready_and_i ? ELS'(32'd1 << c_sel) : '0;
                chk("grant_id_o", 64'(grant_id_o), 64'(c_sel));
                chk("link_v_o", 64'(link_v_o), 64'(c_v));
                chk("link_data_o", 64'(link_data_o), 64'(FW'(link_data_i >> (c_sel * FW))));
                chk("link_ready_and_o", 64'(link_ready_and_o), 64'(c_rdy));
                chk("busy_o", 64'(busy_o), 64'(m_owner >= 0));
                exp_xfer = c_v & link_ready_and_i;
                exp_sel  = c_sel;
                exp_len  = int'(LW'(link_data_i >> (c_sel * FW + CW)));
                if (link_v_o && link_ready_and_i) begin
                    out_log.push_back(link_data_o);
                    grant_log.push_back(int'(grant_id_o));
                    busy_log.push_back(busy_o);
                    cyc_log.push_back(cyc);
                end
            end
        end
    end

    task automatic step();
        if (rdy_force < 0) link_ready_and_i = ($urandom_range(0, 99) < p_rdy);
        else link_ready_and_i = rdy_force[0];
        for (int i = 0; i < ELS; i++) begin
            if (!held[i] && !mute[i] && srcq[i].size() > 0 && $urandom_range(0, 99) < p_valid)
                held[i] = 1'b1;
            link_v_i[i] = held[i];
            link_data_i[i*FW +: FW] = held[i] ? srcq[i][0] : $urandom;
        end
        @(posedge clk_i); #1;
        if (reset_n_i && exp_xfer) begin
            void'(srcq[exp_sel].pop_front());
            held[exp_sel] = 1'b0;
            if (m_owner < 0) begin
                m_ptr = (exp_sel + 1) % ELS;
                if (exp_len > 0) begin
                    m_owner = exp_sel;
                    m_left  = exp_len;
                end
            end else begin
                m_left--;
                if (m_left == 0) m_owner = -1;
            end
        end
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        clear_model();
        link_v_i = '1;
        link_ready_and_i = 1'b1;
        for (int i = 0; i < ELS; i++) link_data_i[i*FW +: FW] = $urandom;
        @(posedge clk_i); #1;
        chk("reset_v_o_inputs_valid", 64'(link_v_o), 64'(0));
        chk("reset_ready_inputs_valid", 64'(link_ready_and_o), 64'(0));
        chk("reset_grant_inputs_valid", 64'(grant_id_o), 64'(0));
        chk("reset_busy_inputs_valid", 64'(busy_o), 64'(0));
        @(posedge clk_i); #1;
        reset_n_i = 1'b1;
        link_v_i = '0;
        link_ready_and_i = 1'b0;
    endtask

    initial begin
        bit rdy_pat[11] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
        bit mut_pat[11] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
        chk_en = 1'b1;
        p_valid = 100; p_rdy = 100; rdy_force = 1;

        // single requester, len=3
        do_reset();
        clear_logs();
        add_pkt(0, 3);
        rdy_force = 1;
        repeat (6) step();
        chk("a_flits_out", 64'(out_log.size()), 64'(4));
        if (busy_log.size() == 4) begin
            chk("a_busy0", 64'(busy_log[0]), 64'(0));
            chk("a_busy1", 64'(busy_log[1]), 64'(1));
            chk("a_busy3", 64'(busy_log[3]), 64'(1));
            chk("a_consecutive", 64'(cyc_log[3] - cyc_log[0]), 64'(3));
        end
        chk("a_model_ptr", 64'(m_ptr), 64'(1));
        link_v_i = '0; #1;
        chk("a_idle_grant_is_ptr", 64'(grant_id_o), 64'(1));

        // requesters 0 and 2, len=2 each
        do_reset();
        clear_logs();
        add_pkt(0, 2); add_pkt(2, 2);
        repeat (8) step();
        chk("b_flits_out", 64'(out_log.size()), 64'(6));
        if (out_log.size() == 6) begin
            for (int k = 0; k < 6; k++) chk("b_src_order", 64'(out_log[k][31:24]), 64'((k < 3) ? 0 : 2));
            chk("b_no_gap", 64'(cyc_log[5] - cyc_log[0]), 64'(5));
        end

        // all four sending single-flit packets
        do_reset();
        clear_logs();
        for (int i = 0; i < ELS; i++) repeat (3) add_pkt(i, 0);
        repeat (14) step();
        chk("c_flits_out", 64'(out_log.size()), 64'(12));
        if (grant_log.size() == 12)
            for (int k = 0; k < 12; k++) chk("c_rotation", 64'(grant_log[k]), 64'(k % 4));

        // len=4 with toggling ready and an upstream bubble
        do_reset();
        clear_logs();
        add_pkt(1, 4); add_pkt(3, 0); add_pkt(3, 0);
        for (int s = 0; s < 11; s++) begin
            rdy_force = int'(rdy_pat[s]);
            mute[1] = mut_pat[s];
            step();
        end
        rdy_force = 1;
        repeat (4) step();
        chk("d_flits_out", 64'(out_log.size()), 64'(7));
        if (out_log.size() == 7) begin
            for (int k = 0; k < 5; k++) begin
                chk("d_locked_src", 64'(out_log[k][31:24]), 64'(1));
                chk("d_flit_order", 64'(out_log[k][15:12]), 64'(k));
            end
            chk("d_next_src", 64'(out_log[5][31:24]), 64'(3));
        end

        // header stalled 5 cycles while another requester turns valid
        do_reset();
        clear_logs();
        add_pkt(0, 1);
        rdy_force = 0;
        for (int s = 0; s < 5; s++) begin
            if (s == 1) add_pkt(1, 0);
            step();
            chk("e_grant_stable", 64'(grant_id_o), 64'(0));
            chk("e_data_stable", 64'(link_data_o), 64'(32'h0000_0027));
        end
        rdy_force = 1;
        repeat (4) step();
        chk("e_flits_out", 64'(out_log.size()), 64'(3));
        if (out_log.size() == 3) chk("e_first_flit", 64'(out_log[0]), 64'(32'h0000_0027));

        // async reset in BUSY with two flits left
        do_reset();
        clear_logs();
        add_pkt(0, 3);
        rdy_force = 1;
        repeat (2) step();
        held[0] = 1'b1;
        link_v_i[0] = 1'b1;
        link_data_i[0 +: FW] = srcq[0][0];
        link_ready_and_i = 1'b1;
        #1;
        chk("f_busy_before_reset", 64'(busy_o), 64'(1));
        #1 reset_n_i = 1'b0;
        #1;
        chk("f_async_v_o", 64'(link_v_o), 64'(0));
        chk("f_async_ready", 64'(link_ready_and_o), 64'(0));
        chk("f_async_busy", 64'(busy_o), 64'(0));
        clear_model();
        link_v_i = '0;
        @(posedge clk_i); #1;
        reset_n_i = 1'b1;
        clear_logs();
        add_pkt(2, 0); add_pkt(0, 0);
        repeat (4) step();
        chk("f_flits_out", 64'(grant_log.size()), 64'(2));
        if (grant_log.size() == 2) begin
            chk("f_first_grant", 64'(grant_log[0]), 64'(0));
            chk("f_second_grant", 64'(grant_log[1]), 64'(2));
        end

        // randomized traffic
        do_reset();
        rdy_force = -1;
        for (int n = 0; n < 3000; n++) begin
            if (n % 500 == 0) begin
                p_valid = $urandom_range(40, 100);
                p_rdy   = $urandom_range(30, 100);
            end
            for (int i = 0; i < ELS; i++)
                if (srcq[i].size() < 20 && $urandom_range(0, 3) == 0) add_pkt(i, $urandom_range(0, 15));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
